instr_capture: RTL and testbench

// Front-end stage feeding the processor datapath: synchronises and debounces the push keys,

---
 rtl/instr_capture.sv | 194 +++++++++++++++++++
 tb/tb_instr_capture.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_capture.sv
// ============================================================================
// Module  : instr_capture
// Brief   : Synchronises and debounces push keys, latches and decodes the switch
//           word on a KEY[3] press, and issues register-peek pulses on KEY[0].
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_capture #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [3:0]  opcode,
    output logic [3:0]  rd,
    output logic [3:0]  rs,
    output logic [3:0]  rt,
    output logic [15:0] imm,
    output logic        imm_flag,
    output logic        illegal,
    output logic        peek_valid,
    output logic [7:0]  instr_count
);

    localparam logic [CNT_W-1:0] C_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int               C_NKEYS    = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // Keys 1/2 and switches 17:16 are not part of the instruction path.
    logic w_unused;
    assign w_unused = ^{KEY[2:1], SW[17:16]};

    logic [C_NKEYS-1:0] w_key_raw;
    assign w_key_raw = {KEY[3], KEY[0]};

    logic [C_NKEYS-1:0] r_key_s1, r_key_s2;
    logic [15:0]        r_sw_s1,  r_sw_s2;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_key_s1 <= '1;
            r_key_s2 <= '1;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_key_s1 <= w_key_raw;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= SW[15:0];
            r_sw_s2  <= r_sw_s1;
        end
    end

    logic [C_NKEYS-1:0] r_deb;
    logic [C_NKEYS-1:0] r_deb_q;
    logic [C_NKEYS-1:0] r_press;

    for (genvar gi = 0; gi < C_NKEYS; gi++) begin : g_deb
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                r_cnt       <= '0;
                r_deb[gi]   <= 1'b1;
                r_deb_q[gi] <= 1'b1;
                r_press[gi] <= 1'b0;
            end else begin
                r_deb_q[gi] <= r_deb[gi];
                r_press[gi] <= r_deb_q[gi] & ~r_deb[gi];
                if (r_key_s2[gi] == r_deb[gi]) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_DEB_LAST) begin
                    r_cnt     <= '0;
                    r_deb[gi] <= r_key_s2[gi];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    logic       w_press0, w_press3, w_key3_up;
    logic [3:0] w_op;
    logic       w_legal, w_itype;

    assign w_press0  = r_press[0];
    assign w_press3  = r_press[1];
    assign w_key3_up = r_deb[1];
    assign w_op      = r_sw_s2[15:12];
    assign w_legal   = (w_op <= 4'd10);
    assign w_itype   = (w_op >= 4'd6);

    state_t      r_state;
    logic        r_instr_valid, r_imm_flag, r_illegal, r_peek_valid;
    logic [3:0]  r_opcode, r_rd, r_rs, r_rt, r_rs_dec, r_rt_dec;
    logic [15:0] r_imm;
    logic [7:0]  r_instr_count;

    // rs/rt normally mirror the decoded fields; a peek overrides them for one cycle.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state       <= S_IDLE;
            r_instr_valid <= 1'b0;
            r_imm_flag    <= 1'b0;
            r_illegal     <= 1'b0;
            r_peek_valid  <= 1'b0;
            r_opcode      <= '0;
            r_rd          <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_rs_dec      <= '0;
            r_rt_dec      <= '0;
            r_imm         <= '0;
            r_instr_count <= '0;
        end else begin
            r_illegal    <= 1'b0;
            r_peek_valid <= 1'b0;
            r_rs         <= r_rs_dec;
            r_rt         <= r_rt_dec;
            case (r_state)
                S_IDLE: begin
                    if (w_press3) begin
                        if (w_legal) begin
                            r_opcode      <= w_op;
                            r_rd          <= r_sw_s2[11:8];
                            r_rt_dec      <= r_sw_s2[3:0];
                            r_rt          <= r_sw_s2[3:0];
                            r_instr_valid <= 1'b1;
                            r_state       <= S_HOLD;
                            if (w_itype) begin
                                r_imm      <= {12'b0, r_sw_s2[7:4]};
                                r_rs_dec   <= '0;
                                r_rs       <= '0;
                                r_imm_flag <= 1'b1;
                            end else begin
                                r_imm      <= '0;
                                r_rs_dec   <= r_sw_s2[7:4];
                                r_rs       <= r_sw_s2[7:4];
                                r_imm_flag <= 1'b0;
                            end
                        end else begin
                            r_illegal <= 1'b1;
                            r_state   <= S_WAIT;
                        end
                    end else if (w_press0) begin
                        r_peek_valid <= 1'b1;
                        r_rs         <= r_sw_s2[11:8];
                        r_rt         <= r_sw_s2[7:4];
                    end
                end
                S_HOLD: begin
                    if (r_instr_valid && instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_instr_count <= r_instr_count + 8'd1;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_key3_up) begin
                        r_state <= S_IDLE;
                    end else if (w_press0) begin
                        r_peek_valid <= 1'b1;
                        r_rs         <= r_sw_s2[11:8];
                        r_rt         <= r_sw_s2[7:4];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign instr_valid = r_instr_valid;
    assign opcode      = r_opcode;
    assign rd          = r_rd;
    assign rs          = r_rs;
    assign rt          = r_rt;
    assign imm         = r_imm;
    assign imm_flag    = r_imm_flag;
    assign illegal     = r_illegal;
    assign peek_valid  = r_peek_valid;
    assign instr_count = r_instr_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_capture.sv
// ============================================================================
// Module  : tb_instr_capture
// Brief   : Directed self-checking bench for instr_capture (DEBOUNCE_CYCLES=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_capture;

    logic        clk;
    logic        rst_n;
    logic [3:0]  key;
    logic [17:0] sw;
    logic        ready;
    logic        valid, imm_flag, illegal, peek;
    logic [3:0]  opcode, rd, rs, rt;
    logic [15:0] imm;
    logic [7:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    instr_capture #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .KEY        (key),
        .SW         (sw),
        .instr_ready(ready),
        .instr_valid(valid),
        .opcode     (opcode),
        .rd         (rd),
        .rs         (rs),
        .rt         (rt),
        .imm        (imm),
        .imm_flag   (imm_flag),
        .illegal    (illegal),
        .peek_valid (peek),
        .instr_count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits up to 'bound' cycles for instr_valid; a timeout is a failed comparison.
    task automatic wait_valid(input int bound);
        int   k;
        logic seen;
        seen = 1'b0;
        for (k = 0; k < bound && !seen; k++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        check("wait_valid", {31'b0, seen}, 32'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic saw_valid;
        rst_n = 1'b0;
        key   = 4'hF;
        sw    = '0;
        ready = 1'b0;
        tick(3);
        check("rst_valid", {31'b0, valid}, 0);
        check("rst_count", {24'b0, count}, 0);
        check("rst_fields", {opcode, rd, rs, rt, imm}, 0);
        check("rst_flags", {29'b0, imm_flag, illegal, peek}, 0);
        rst_n = 1'b1;
        tick(2);

        // R-type, ready already high: single-cycle valid at exact latency
        sw = 18'h01234; ready = 1'b1; key[3] = 1'b0;
        tick(7);
        check("t1_early", {31'b0, valid}, 0);
        tick(1);
        check("t1_valid", {31'b0, valid}, 1);
        check("t1_fields", {opcode, rd, rs, rt}, 32'h1234);
        check("t1_imm", {15'b0, imm_flag, imm}, 0);
        tick(1);
        check("t1_drop", {31'b0, valid}, 0);
        check("t1_count", {24'b0, count}, 1);
        tick(1);
        key[3] = 1'b1;
        tick(12);

        // I-type held while ready low
        sw = 18'h07A53; ready = 1'b0; key[3] = 1'b0;
        tick(8);
        check("t2_valid", {31'b0, valid}, 1);
        check("t2_fields", {opcode, rd, rs, rt}, 32'h7A03);
        check("t2_imm", {15'b0, imm_flag, imm}, 32'h10005);
        tick(5);
        check("t2_hold", {31'b0, valid}, 1);
        check("t2_hold_imm", {16'b0, imm}, 32'h0005);
        check("t2_count_wait", {24'b0, count}, 1);
        ready = 1'b1;
        tick(1);
        check("t2_drop", {31'b0, valid}, 0);
        check("t2_count", {24'b0, count}, 2);
        key[3] = 1'b1;
        tick(12);

        // Bounce shorter than the debounce window
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            key[3] = ~key[3];
            tick(1);
            saw_valid |= valid;
            tick(1);
            saw_valid |= valid;
        end
        key[3] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            saw_valid |= valid;
        end
        check("t3_no_valid", {31'b0, saw_valid}, 0);
        check("t3_count", {24'b0, count}, 2);

        // Illegal opcode
        sw = 18'h0C000; key[3] = 1'b0;
        tick(8);
        check("t4_illegal", {31'b0, illegal}, 1);
        check("t4_valid", {31'b0, valid}, 0);
        tick(1);
        check("t4_pulse_end", {31'b0, illegal}, 0);
        check("t4_count", {24'b0, count}, 2);
        key[3] = 1'b1;
        tick(12);

        // Simultaneous KEY0/KEY3: KEY3 wins
        sw = 18'h00123; ready = 1'b0; key = 4'b0110;
        tick(8);
        check("t5_valid", {31'b0, valid}, 1);
        check("t5_peek", {31'b0, peek}, 0);
        check("t5_fields", {opcode, rd, rs, rt}, 32'h0123);
        ready = 1'b1;
        tick(1);
        check("t5_count", {24'b0, count}, 3);
        key = 4'hF;
        tick(12);

        // Peek alone in IDLE
        sw = 18'h00AB0; key[0] = 1'b0;
        tick(8);
        check("t6_peek", {31'b0, peek}, 1);
        check("t6_peek_regs", {rs, rt}, 32'hAB);
        check("t6_rd", {opcode, rd}, 32'h01);
        check("t6_valid", {31'b0, valid}, 0);
        tick(1);
        check("t6_peek_end", {31'b0, peek}, 0);
        check("t6_restore", {rs, rt}, 32'h23);
        key[0] = 1'b1;
        tick(12);

        // Count wrap
        sw = 18'h01234; ready = 1'b1;
        for (int i = 0; i < 252; i++) begin
            key[3] = 1'b0;
            wait_valid(20);
            key[3] = 1'b1;
            tick(10);
        end
        check("t7_count255", {24'b0, count}, 255);
        key[3] = 1'b0;
        wait_valid(20);
        key[3] = 1'b1;
        tick(10);
        check("t7_wrap", {24'b0, count}, 0);

        // Async reset while holding
        sw = 18'h05678; ready = 1'b0; key[3] = 1'b0;
        tick(8);
        check("t8_hold", {31'b0, valid}, 1);
        #2;
        rst_n = 1'b0;
        key   = 4'hF;
        #1;
        check("t8_rst_valid", {31'b0, valid}, 0);
        check("t8_rst_fields", {opcode, rd, rs, rt, imm}, 0);
        check("t8_rst_count", {24'b0, count}, 0);
        tick(2);
        rst_n = 1'b1;
        tick(12);
        check("t8_after", {31'b0, valid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
